aes_round_key_server: RTL and testbench
=======================================

Name: aes_round_key_server

Overview:
- Consumer side of the AES-128 key expansion output. Captures the cipher key and the packed 1280-bit SuperKey into an 11-entry round-key store.
- Serves the stored keys one per handshake to the AES round datapath. Order is forward (rounds 0..10) for encryption or reverse (10..0) for decryption.
- Sits between the key expansion block and the cipher/inverse-cipher round engines.

Parameters:
- DATA_W, 128, round-key width in bits.
- NO_ROUNDS, 10, number of expanded round keys in SuperKey. Store depth is NO_ROUNDS+1.
- IDX_W, 4, width of the round index; must hold NO_ROUNDS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cipher_valid  input  1  pulse; latch cipher_key into slot 0.
- cipher_key  input  DATA_W  original 128-bit key (round-0 key).
- superkey_valid  input  1  pulse; tie to expansion valid_out[NO_ROUNDS-1]; latch SuperKey.
- SuperKey  input  NO_ROUNDS*DATA_W  packed round keys; round k (1..NO_ROUNDS) at SuperKey[(NO_ROUNDS-k)*DATA_W +: DATA_W].
- start  input  1  pulse; begin serving a key sequence.
- decrypt  input  1  sampled with start; 0 = forward order, 1 = reverse order.
- rk_ready  input  1  downstream accepts round_key.
- rk_valid  output  1  round_key / round_idx valid.
- round_key  output  DATA_W  current round key.
- round_idx  output  IDX_W  round number of round_key.
- rk_last  output  1  current key is the final one of the sequence.
- busy  output  1  sequence in progress.
- keys_loaded  output  1  both slot 0 and slots 1..NO_ROUNDS hold a valid key set.

Behaviour:
- Reset (async, reset=0): all store slots = 0; rk_valid, rk_last, busy, keys_loaded = 0; round_key = 0; round_idx = 0; FSM = IDLE.
- Loading (IDLE only):
  - cipher_valid=1: slot0 <= cipher_key; set an internal cipher_ok flag; clear keys_loaded.
  - superkey_valid=1: slots 1..NO_ROUNDS <= unpacked SuperKey; keys_loaded <= cipher_ok.
  - Both pulses in the same cycle: both captured; keys_loaded=1 the next cycle.
  - Either pulse while busy=1: ignored; store and flags unchanged.
- FSM has two states, IDLE and SERVE.
- IDLE -> SERVE on start=1 && keys_loaded=1. At that edge:
  - busy <= 1; rk_valid <= 1.
  - idx <= decrypt ? NO_ROUNDS : 0; dir latched from decrypt.
  - round_key <= slot[idx]; round_idx <= idx.
  - First key is valid the cycle after start (latency 1).
- start with keys_loaded=0, or start while busy: ignored, no state change.
- SERVE handshake: a transfer occurs when rk_valid && rk_ready.
  - No transfer: round_key, round_idx, rk_last held stable.
  - Transfer, not last: idx steps +1 (forward) or -1 (reverse); the next key is registered and rk_valid stays 1. No bubbles, so 11 keys in 11 cycles with rk_ready held high.
- rk_last = 1 when idx = NO_ROUNDS (forward) or idx = 0 (reverse).
- SERVE -> IDLE on a transfer with rk_last=1. Next cycle: rk_valid=0, rk_last=0, busy=0. round_key and round_idx hold their final values. keys_loaded stays 1, so an immediate re-start is allowed.
- idx never wraps; reaching the final index is the only exit from SERVE.
- Reset asserted mid-sequence: immediate return to the reset state; the store is lost.

Optional Feature:
- Macro ROUND_KEY_ZEROIZE_EN.
- Defined: on the final transfer, all slots are cleared to 0, keys_loaded <= 0 and cipher_ok <= 0. round_key is forced to 0 whenever rk_valid=0. Every sequence therefore needs a fresh load.
- Undefined: the store is retained, keys_loaded stays 1, and round_key holds its last value.

Test Plan:
- Load cipher_key 2b7e151628aed2a6abf7158809cf4f3c plus the matching NIST SuperKey; start, decrypt=0, rk_ready=1 -> 11 consecutive transfers.
  - round_idx 0..10.
  - Key 0 = 2b7e1516..4f3c; key 1 = a0fafe1788542cb123a339392a6c7605; key 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - rk_last only on idx 10; busy falls the cycle after.
- Same load; start, decrypt=1 -> first key d014f9a8c9ee2589e13f0cc8b6630ca6 (idx 10), last key 2b7e1516..4f3c (idx 0), with rk_last on it.
- Forward sequence with rk_ready toggled 1,0,0,1 repeatedly -> round_key and round_idx stable across stall cycles; no key skipped or duplicated; 11 transfers total.
- start before any load, then superkey_valid alone -> no rk_valid and keys_loaded=0; after a cipher_valid + superkey_valid sequence, start succeeds.
- superkey_valid with different data mid-sequence -> the served keys still match the original set; start pulses during SERVE are ignored.
- Reset=0 at transfer 5 -> all outputs 0 asynchronously; the next start is ignored until a reload.
  - With ROUND_KEY_ZEROIZE_EN: after the final transfer keys_loaded=0, and a re-start is ignored.

Source files
------------

// File: rtl/aes_round_key_server.sv
// aes_round_key_server
// Holds the eleven AES-128 round keys (cipher key plus the ten expanded keys
// delivered as one packed SuperKey) and streams them out one per valid/ready
// handshake. Forward order 0..NO_ROUNDS feeds encryption; reverse order
// NO_ROUNDS..0 feeds decryption.
//
// Optional build macro: ROUND_KEY_ZEROIZE_EN
//   When defined, the store and the loaded flags are wiped on the final
//   transfer of every sequence, and round_key reads 0 whenever it is not
//   valid. Each sequence then needs a fresh load.
module aes_round_key_server #(
  parameter int DATA_W    = 128,
  parameter int NO_ROUNDS = 10,
  parameter int IDX_W     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cipher_valid,
  input  logic [DATA_W-1:0]         cipher_key,
  input  logic                      superkey_valid,
  input  logic [NO_ROUNDS*DATA_W-1:0] SuperKey,
  input  logic                      start,
  input  logic                      decrypt,
  input  logic                      rk_ready,
  output logic                      rk_valid,
  output logic [DATA_W-1:0]         round_key,
  output logic [IDX_W-1:0]          round_idx,
  output logic                      rk_last,
  output logic                      busy,
  output logic                      keys_loaded
);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NO_ROUNDS);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  state_t state;
  state_t state_next;

  logic [DATA_W-1:0] key_store [0:NO_ROUNDS];
  logic              cipher_ok;
  logic              keys_loaded_q;
  logic              dir_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] round_key_q;
  logic [IDX_W-1:0]  round_idx_q;

  logic              launch;
  logic              transfer;
  logic              at_last;
  logic              final_xfer;
  logic [IDX_W-1:0]  first_idx;
  logic [IDX_W-1:0]  step_idx;

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a start only launches once a full key set is present, and the
  // only way out of SERVE is handing over the final key
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch)     state_next = SERVE;
      SERVE:   if (final_xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake decode and status outputs derived from the current state
  always_comb begin
    rk_valid   = (state == SERVE);
    busy       = (state == SERVE);
    at_last    = dir_q ? (idx_q == '0) : (idx_q == LAST_IDX);
    rk_last    = (state == SERVE) && at_last;
    transfer   = rk_valid && rk_ready;
    final_xfer = transfer && at_last;
    launch     = (state == IDLE) && start && keys_loaded_q;
    first_idx  = decrypt ? LAST_IDX : '0;
    step_idx   = dir_q ? (idx_q - ONE_IDX) : (idx_q + ONE_IDX);
  end

  // Key store and load flags; loads are only honoured while idle so a running
  // sequence always sees one consistent key set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k <= NO_ROUNDS; k++) begin
        key_store[k] <= '0;
      end
      cipher_ok     <= 1'b0;
      keys_loaded_q <= 1'b0;
    end else if (state == IDLE) begin
      if (cipher_valid) begin
        key_store[0] <= cipher_key;
        cipher_ok    <= 1'b1;
      end
      if (superkey_valid) begin
        for (int k = 1; k <= NO_ROUNDS; k++) begin
          key_store[k] <= SuperKey[(NO_ROUNDS-k)*DATA_W +: DATA_W];
        end
        keys_loaded_q <= cipher_ok | cipher_valid;
      end else if (cipher_valid) begin
        keys_loaded_q <= 1'b0;
      end
    end
`ifdef ROUND_KEY_ZEROIZE_EN
    else if (final_xfer) begin
      for (int k = 0; k <= NO_ROUNDS; k++) begin
        key_store[k] <= '0;
      end
      cipher_ok     <= 1'b0;
      keys_loaded_q <= 1'b0;
    end
`endif
  end

  // Output key register: load the first key on launch, advance on each
  // non-final transfer, otherwise hold so stalls see a stable key
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q       <= '0;
      dir_q       <= 1'b0;
      round_key_q <= '0;
      round_idx_q <= '0;
    end else if (launch) begin
      idx_q       <= first_idx;
      dir_q       <= decrypt;
      round_key_q <= key_store[first_idx];
      round_idx_q <= first_idx;
    end else if (transfer && !at_last) begin
      idx_q       <= step_idx;
      round_key_q <= key_store[step_idx];
      round_idx_q <= step_idx;
    end
`ifdef ROUND_KEY_ZEROIZE_EN
    else if (final_xfer) begin
      round_key_q <= '0;
    end
`endif
  end

  assign round_key   = round_key_q;
  assign round_idx   = round_idx_q;
  assign keys_loaded = keys_loaded_q;

endmodule

// File: tb/tb_aes_round_key_server.sv
// tb_aes_round_key_server
// Scoreboarded bench for the round-key server: expected key sequences are
// queued when a start is issued and checked against every valid cycle.
// Honours ROUND_KEY_ZEROIZE_EN when the build defines it.
module tb_aes_round_key_server;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          cipher_valid;
  logic [127:0]  cipher_key;
  logic          superkey_valid;
  logic [1279:0] SuperKey;
  logic          start;
  logic          decrypt;
  logic          rk_ready;
  logic          rk_valid;
  logic [127:0]  round_key;
  logic [3:0]    round_idx;
  logic          rk_last;
  logic          busy;
  logic          keys_loaded;

  logic [127:0]  nist [0:10];
  logic [1279:0] good_sk;
  exp_t          sb [$];
  exp_t          mon_exp;
  int            vectors;
  int            miscompares;

  aes_round_key_server #(
    .DATA_W(128),
    .NO_ROUNDS(10),
    .IDX_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cipher_valid(cipher_valid),
    .cipher_key(cipher_key),
    .superkey_valid(superkey_valid),
    .SuperKey(SuperKey),
    .start(start),
    .decrypt(decrypt),
    .rk_ready(rk_ready),
    .rk_valid(rk_valid),
    .round_key(round_key),
    .round_idx(round_idx),
    .rk_last(rk_last),
    .busy(busy),
    .keys_loaded(keys_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every valid cycle must present the queue head; it is popped
  // only when the handshake completes, so stalls must hold the same key
  always @(negedge clk) begin
    if (reset === 1'b1 && rk_valid === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_key: got idx=%0d key=%h, expected no valid key", round_idx, round_key);
      end else begin
        mon_exp = sb[0];
        if (round_key !== mon_exp.key || round_idx !== mon_exp.idx || rk_last !== mon_exp.last) begin
          miscompares++;
          $display("[TB] FAIL key_stream: got idx=%0d last=%b key=%h, expected idx=%0d last=%b key=%h",
                   round_idx, rk_last, round_key, mon_exp.idx, mon_exp.last, mon_exp.key);
        end
        if (rk_ready === 1'b1) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_keys();
    cipher_key     = nist[0];
    SuperKey       = good_sk;
    cipher_valid   = 1'b1;
    superkey_valid = 1'b1;
    tick();
    cipher_valid   = 1'b0;
    superkey_valid = 1'b0;
  endtask

  task automatic push_expected(input bit dec);
    exp_t e;
    int   r;
    for (int n = 0; n <= 10; n++) begin
      r      = dec ? 10 - n : n;
      e.idx  = 4'(r);
      e.key  = nist[r];
      e.last = (n == 10);
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input bit dec);
    start   = 1'b1;
    decrypt = dec;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
  endtask

  // Drives rk_ready per mode until the sequence ends. Modes: 0 ready high,
  // 1 ready pattern 1,0,0,1, 2 ready high with loads/starts injected,
  // 3 ready high and return mid-cycle after the fifth transfer
  task automatic serve(input int mode, output int xfers, output int cycles, output bit timeout);
    bit done;
    bit early;
    done   = 1'b0;
    early  = 1'b0;
    xfers  = 0;
    cycles = 0;
    for (int i = 0; i < 80; i++) begin
      rk_ready       = (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
      superkey_valid = (mode == 2) && (i == 2);
      SuperKey       = ((mode == 2) && (i == 2)) ? ~good_sk : good_sk;
      cipher_valid   = (mode == 2) && (i == 4);
      cipher_key     = ((mode == 2) && (i == 4)) ? ~nist[0] : nist[0];
      start          = (mode == 2) && (i == 3 || i == 5);
      decrypt        = (mode == 2) && (i == 5);
      @(negedge clk);
      if (busy !== 1'b1) begin
        done = 1'b1;
        break;
      end
      cycles++;
      if (rk_valid === 1'b1 && rk_ready === 1'b1) xfers++;
      if (mode == 3 && xfers == 5) begin
        early = 1'b1;
        break;
      end
      tick();
    end
    timeout = !done && !early;
    if (!early) begin
      rk_ready       = 1'b0;
      superkey_valid = 1'b0;
      cipher_valid   = 1'b0;
      start          = 1'b0;
      decrypt        = 1'b0;
      SuperKey       = good_sk;
      cipher_key     = nist[0];
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    vectors++;
    if ({rk_valid, busy, rk_last, keys_loaded, round_idx, round_key} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got v=%b b=%b l=%b kl=%b idx=%0d key=%h, expected all zero",
               rk_valid, busy, rk_last, keys_loaded, round_idx, round_key);
    end
    reset = 1'b1;
    tick();
    vectors++;
    if ({rk_valid, busy, rk_last, keys_loaded, round_idx, round_key} !== '0) begin
      miscompares++;
      $display("[TB] FAIL post_reset_idle: got v=%b b=%b kl=%b, expected all zero", rk_valid, busy, keys_loaded);
    end
  endtask

  task automatic test_load_gating();
    int xf, cy;
    bit to;
    pulse_start(1'b0);
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_unloaded: got v=%b b=%b, expected 0 0", rk_valid, busy);
    end
    tick();
    SuperKey       = good_sk;
    superkey_valid = 1'b1;
    tick();
    superkey_valid = 1'b0;
    vectors++;
    if (keys_loaded !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL superkey_alone: got keys_loaded=%b, expected 0", keys_loaded);
    end
    pulse_start(1'b0);
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_partial: got rk_valid=%b, expected 0", rk_valid);
    end
    tick();
    cipher_key   = nist[0];
    cipher_valid = 1'b1;
    tick();
    cipher_valid = 1'b0;
    vectors++;
    if (keys_loaded !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL cipher_alone: got keys_loaded=%b, expected 0", keys_loaded);
    end
    superkey_valid = 1'b1;
    tick();
    superkey_valid = 1'b0;
    vectors++;
    if (keys_loaded !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL cipher_then_superkey: got keys_loaded=%b, expected 1", keys_loaded);
    end
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(0, xf, cy, to);
    vectors++;
    if (to || xf != 11) begin
      miscompares++;
      $display("[TB] FAIL staged_load_run: got transfers=%0d timeout=%b, expected 11 0", xf, to);
    end
  endtask

  task automatic test_forward();
    int xf, cy;
    bit to;
    load_keys();
    vectors++;
    if (keys_loaded !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL joint_load: got keys_loaded=%b, expected 1", keys_loaded);
    end
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(0, xf, cy, to);
    vectors++;
    if (to || xf != 11 || cy != 11 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL forward_count: got transfers=%0d cycles=%0d left=%0d, expected 11 11 0", xf, cy, sb.size());
    end
    vectors++;
    if (rk_valid !== 1'b0 || rk_last !== 1'b0 || busy !== 1'b0 || round_idx !== 4'd10) begin
      miscompares++;
      $display("[TB] FAIL forward_end: got v=%b l=%b b=%b idx=%0d, expected 0 0 0 10", rk_valid, rk_last, busy, round_idx);
    end
`ifdef ROUND_KEY_ZEROIZE_EN
    vectors++;
    if (round_key !== '0 || keys_loaded !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zeroize_end: got key=%h kl=%b, expected 0 0", round_key, keys_loaded);
    end
`else
    vectors++;
    if (round_key !== nist[10] || keys_loaded !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL hold_end: got key=%h kl=%b, expected %h 1", round_key, keys_loaded, nist[10]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    int xf, cy;
    bit to;
`ifdef ROUND_KEY_ZEROIZE_EN
    pulse_start(1'b1);
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL restart_after_zeroize: got rk_valid=%b, expected 0", rk_valid);
    end
    tick();
    load_keys();
`endif
    push_expected(1'b1);
    pulse_start(1'b1);
    serve(0, xf, cy, to);
    vectors++;
    if (to || xf != 11 || cy != 11 || round_idx !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reverse_run: got transfers=%0d cycles=%0d idx=%0d, expected 11 11 0", xf, cy, round_idx);
    end
  endtask

  task automatic test_stall();
    int xf, cy;
    bit to;
    load_keys();
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(1, xf, cy, to);
    vectors++;
    if (to || xf != 11 || cy != 21 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stall_run: got transfers=%0d cycles=%0d left=%0d, expected 11 21 0", xf, cy, sb.size());
    end
  endtask

  task automatic test_busy_ignores();
    int xf, cy;
    bit to;
    load_keys();
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(2, xf, cy, to);
    vectors++;
    if (to || xf != 11) begin
      miscompares++;
      $display("[TB] FAIL busy_inject_run: got transfers=%0d timeout=%b, expected 11 0", xf, to);
    end
`ifdef ROUND_KEY_ZEROIZE_EN
    pulse_start(1'b0);
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0 || keys_loaded !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zeroize_restart: got v=%b kl=%b, expected 0 0", rk_valid, keys_loaded);
    end
    tick();
`else
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(0, xf, cy, to);
    vectors++;
    if (to || xf != 11) begin
      miscompares++;
      $display("[TB] FAIL store_retained: got transfers=%0d timeout=%b, expected 11 0", xf, to);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int xf, cy;
    bit to;
    load_keys();
    push_expected(1'b0);
    pulse_start(1'b0);
    serve(3, xf, cy, to);
    vectors++;
    if (to || xf != 5) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_transfers: got %0d timeout=%b, expected 5 0", xf, to);
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({rk_valid, busy, rk_last, keys_loaded, round_idx, round_key} !== '0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got v=%b b=%b l=%b kl=%b idx=%0d key=%h, expected all zero",
               rk_valid, busy, rk_last, keys_loaded, round_idx, round_key);
    end
    sb.delete();
    rk_ready = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rk_ready = 1'b1;
    pulse_start(1'b0);
    @(negedge clk);
    vectors++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || keys_loaded !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_after_reset: got v=%b b=%b kl=%b, expected 0 0 0", rk_valid, busy, keys_loaded);
    end
    tick();
    rk_ready = 1'b0;
    load_keys();
    push_expected(1'b1);
    pulse_start(1'b1);
    serve(0, xf, cy, to);
    vectors++;
    if (to || xf != 11 || sb.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL reload_after_reset: got transfers=%0d left=%0d, expected 11 0", xf, sb.size());
    end
  endtask

  initial begin
    nist[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    nist[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    nist[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    nist[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    nist[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    nist[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    nist[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    nist[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    nist[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    nist[9]  = 128'hac7766f319fadc2128d12941575c006e;
    nist[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int k = 1; k <= 10; k++) good_sk[(10-k)*128 +: 128] = nist[k];
    vectors        = 0;
    miscompares    = 0;
    reset          = 1'b0;
    cipher_valid   = 1'b0;
    cipher_key     = '0;
    superkey_valid = 1'b0;
    SuperKey       = '0;
    start          = 1'b0;
    decrypt        = 1'b0;
    rk_ready       = 1'b0;

    test_reset();
    test_load_gating();
    test_forward();
    test_back_to_back();
    test_stall();
    test_busy_ignores();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
